dflow_pkt_builder: RTL and testbench
====================================

Name: dflow_pkt_builder

Overview:
- Downstream stage of dflow_generator; consumes replayed 5-tuple + packet length records and emits complete Ethernet/IPv4/L4 frames on a 256-bit AXI-Stream master toward the NetFPGA output path.
- Header is built from tuple fields and parameterised MACs; the payload is a deterministic byte pattern, so checkers can validate frames without a reference copy.

Parameters:
ACTION_TUPLE_WIDTH, 128, width of tuple input bus; low PKT_TUPLE_WIDTH bits used
PKT_TUPLE_WIDTH, 104, 5-tuple width: [103:72] src_ip, [71:40] dst_ip, [39:24] src_port, [23:8] dst_port, [7:0] proto
PKT_LEN_WIDTH, 16, frame length in bytes, FCS excluded
C_M_AXIS_DATA_WIDTH, 256, stream data width (32 bytes per beat)
C_M_AXIS_TUSER_WIDTH, 128, NetFPGA tuser width
MIN_PKT_LEN, 60, lower clamp on frame length
MAX_PKT_LEN, 1514, upper clamp on frame length
SRC_MAC, 48'h000000000001, Ethernet source address
DST_MAC, 48'hFFFFFFFFFFFF, Ethernet destination address
SRC_PORT_TUSER, 8'h01, value driven in tuser[23:16]

Ports:
clk  in  1  single clock (qdr_clk domain)
rst  in  1  synchronous, active-high reset
fivetuple_data_in  in  ACTION_TUPLE_WIDTH  tuple record from generator
pkt_len_in  in  PKT_LEN_WIDTH  requested frame length
tuple_in_vld  in  1  record valid
tuple_in_ready  out  1  record accepted when vld&&ready
m_axis_tdata  out  256  frame data; byte 0 of frame in tdata[7:0]
m_axis_tkeep  out  32  byte enables
m_axis_tuser  out  128  [15:0] frame length, [23:16] SRC_PORT_TUSER, [31:24] 0, rest 0
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of frame
pkt_count  out  32  frames completed (counts tlast handshakes), wraps

Behaviour:
- Reset: tuple_in_ready=0 during rst, then 1; tvalid=0, tlast=0, tdata/tkeep/tuser=0, pkt_count=0, IP ID counter=0, FSM=IDLE.
- FSM: IDLE -> CALC -> HDR0 -> HDR1 -> PAY (if beats>2) -> IDLE after the tlast handshake.
- IDLE: tuple_in_ready=1. On vld&&ready, latch the tuple and L=clamp(pkt_len_in, MIN_PKT_LEN, MAX_PKT_LEN), then go to CALC. A single bubble is inserted, so the first tvalid appears 2 cycles after acceptance. tuple_in_ready=0 in all other states.
- CALC: compute beats=ceil(L/32), IPv4 total_len=L-14, UDP len=L-34, checksum.
- Frame layout by byte offset:
  - 0-5: DST_MAC
  - 6-11: SRC_MAC
  - 12-13: 0x0800
  - 14: 0x45; 15: 0x00
  - 16-17: total_len
  - 18-19: IP ID (16-bit counter, increments per accepted record, wraps)
  - 20-21: 0x4000
  - 22: TTL 0x40; 23: proto
  - 24-25: checksum
  - 26-29: src_ip; 30-33: dst_ip
  - 34-35: src_port; 36-37: dst_port
  - 38-39: UDP len if proto==0x11, else 0
  - 40-41: 0
  - >=42: byte value = offset[7:0]
  - Multi-byte fields are big-endian on the wire.
- AXIS rules:
  - Beat content is held stable while tvalid && !tready.
  - Advance only on the tvalid&&tready handshake.
  - tkeep is all-ones except on the last beat, where it equals (1<<(L mod 32))-1, or all-ones if L mod 32==0.
  - tuser is valid on every beat of the frame.
- Boundaries:
  - L<=64 gives exactly 2 beats; HDR1 carries tlast.
  - Clamped lengths are reported in tuser and length fields.
  - pkt_count wraps at 2^32.
- Reset mid-frame: the frame is aborted; tvalid drops the next cycle with no tlast; the partial frame is discarded downstream.

Optional Feature:
- DFLOW_PKT_IP_CSUM_EN defined: bytes 24-25 carry the true IPv4 header checksum, computed in CALC as the one's-complement of the 16-bit one's-complement sum of the ten header words, with the checksum field taken as 0. Folding fits in the CALC cycle, so latency is unchanged.
- Undefined: bytes 24-25 = 0x0000; the CALC state remains, so timing is identical.

Decomposition:
- Shared package dflow_pkg: tuple field offsets/widths, ETHERTYPE_IPV4, IP_TTL, IP_FLAGS_DF, PROTO_UDP, beat-width constants, FSM state enum.
- One sub-module, dflow_ipv4_csum: combinational checksum of the 20-byte header, instantiated only under DFLOW_PKT_IP_CSUM_EN.

Test Plan:
- len 60, tready=1 -> 2 beats; beat1 tkeep=0x0FFFFFFF, tlast on beat1; total_len=0x002E; pkt_count=1.
- len 100 -> 4 beats; last tkeep=0x0000000F; byte 99=0x63.
- len 20, then len 2000 -> clamped to 60 (2 beats) and 1514 (48 beats, last tkeep=0x000003FF); tuser[15:0]=60 and 1514.
- First record after reset (csum enabled): src 192.168.0.1, dst 192.168.0.199, proto 0x11, len 129 -> total_len 0x0073, ID 0, checksum 0xB861; with the macro off, checksum 0x0000.
- tready toggled 1-0-0-1 mid-frame -> tdata/tkeep/tlast stable while stalled; no beat lost or duplicated; tuple_in_ready stays 0 until the tlast handshake.
- rst asserted during beat 3 of a 1514-byte frame -> next cycle tvalid=0, pkt_count=0, tuple_in_ready=1 after reset release; next frame starts at IP ID 0.

Source files
------------

// File: rtl/dflow_pkg.sv
// Shared constants, tuple layout and FSM encoding for the dflow packet builder.
package dflow_pkg;

  localparam int LEN_W      = 11;  // holds any clamped frame length (<= 1514)
  localparam int BEAT_W     = 6;   // beat index; a max-size frame is 48 beats
  localparam int BEAT_BYTES = 32;
  localparam int HDR_BYTES  = 42;  // Ethernet + IPv4 + L4 ports/len + pad

  localparam logic [15:0] ETH_HDR_BYTES     = 16'd14;
  localparam logic [15:0] ETH_IP_HDR_BYTES  = 16'd34;
  localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL        = 8'h45;
  localparam logic [7:0]  IP_TOS            = 8'h00;
  localparam logic [15:0] IP_FLAGS_DF       = 16'h4000;
  localparam logic [7:0]  IP_TTL            = 8'h40;
  localparam logic [7:0]  PROTO_UDP         = 8'h11;

  // Field order mirrors the generator's 104-bit tuple, MSB first.
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  proto;
  } tuple_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_HDR0,
    S_HDR1,
    S_PAY
  } state_t;

  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
    if (len < lo) return lo;
    if (len > hi) return hi;
    return len;
  endfunction

endpackage

// File: rtl/dflow_pkt_builder_if.sv
// AXI-Stream link carrying built frames from dflow_pkt_builder to the output path.
interface dflow_pkt_builder_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/dflow_ipv4_csum.sv
// Combinational IPv4 header checksum over ten 16-bit words (checksum field supplied as 0).
module dflow_ipv4_csum (
  input  logic [159:0] ip_hdr,
  output logic [15:0]  csum
);
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Two folds suffice: ten words sum below 2^20, and the first fold's carry cannot ripple again.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) sum = sum + 20'(ip_hdr[16*i +: 16]);
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    csum  = ~fold2;
  end
endmodule

// File: rtl/dflow_pkt_builder.sv
// Builds Ethernet/IPv4/L4 frames from tuple+length records onto a 256-bit AXI-Stream.
// Optional: define DFLOW_PKT_IP_CSUM_EN for a true IPv4 checksum (otherwise 0x0000).
module dflow_pkt_builder
  import dflow_pkg::*;
#(
  parameter int          ACTION_TUPLE_WIDTH   = 128,
  parameter int          PKT_TUPLE_WIDTH      = 104,
  parameter int          PKT_LEN_WIDTH        = 16,
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter int          MIN_PKT_LEN          = 60,
  parameter int          MAX_PKT_LEN          = 1514,
  parameter logic [47:0] SRC_MAC              = 48'h000000000001,
  parameter logic [47:0] DST_MAC              = 48'hFFFFFFFFFFFF,
  parameter logic [7:0]  SRC_PORT_TUSER       = 8'h01
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ACTION_TUPLE_WIDTH-1:0] fivetuple_data_in,
  input  logic [PKT_LEN_WIDTH-1:0]      pkt_len_in,
  input  logic                          tuple_in_vld,
  output logic                          tuple_in_ready,
  dflow_pkt_builder_if.master           m_axis,
  output logic [31:0]                   pkt_count
);
  localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;

  state_t              state_q, state_d;
  tuple_t              tuple_q;
  logic [LEN_W-1:0]    len_q;
  logic [15:0]         ip_id_q, frame_id_q, total_len_q, l4_len_q, csum_q;
  logic [BEAT_W-1:0]   beats_q, beat_q;
  logic [KEEP_W-1:0]   last_keep_q;
  logic [31:0]         pkt_count_q;
  logic                in_ready, frame_valid, accept, beat_hs, last_beat;
  logic [15:0]         total_len_w, udp_len_w, csum_w;
  logic [8*HDR_BYTES-1:0] hdr_flat;
  logic                unused_tuple_bits;

  assign unused_tuple_bits = ^fivetuple_data_in[ACTION_TUPLE_WIDTH-1:PKT_TUPLE_WIDTH];

  assign tuple_in_ready = in_ready && !rst;
  assign accept         = tuple_in_ready && tuple_in_vld;
  assign beat_hs        = frame_valid && m_axis.tready;
  assign last_beat      = (beat_q == beats_q - BEAT_W'(1));
  assign total_len_w    = 16'(len_q) - ETH_HDR_BYTES;
  assign udp_len_w      = 16'(len_q) - ETH_IP_HDR_BYTES;
  assign pkt_count      = pkt_count_q;

`ifdef DFLOW_PKT_IP_CSUM_EN
  dflow_ipv4_csum u_csum (
    .ip_hdr ({IP_VER_IHL, IP_TOS, total_len_w, frame_id_q, IP_FLAGS_DF, IP_TTL,
              tuple_q.proto, 16'h0000, tuple_q.src_ip, tuple_q.dst_ip}),
    .csum   (csum_w)
  );
`else
  assign csum_w = 16'h0000;
`endif

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    frame_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (tuple_in_vld) state_d = S_CALC;
      end
      S_CALC: state_d = S_HDR0;
      S_HDR0: begin
        frame_valid = 1'b1;
        if (m_axis.tready) state_d = S_HDR1;
      end
      S_HDR1: begin
        frame_valid = 1'b1;
        if (m_axis.tready) state_d = (beats_q > BEAT_W'(2)) ? S_PAY : S_IDLE;
      end
      S_PAY: begin
        frame_valid = 1'b1;
        if (m_axis.tready && last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tuple_q     <= '0;
      len_q       <= '0;
      ip_id_q     <= '0;
      frame_id_q  <= '0;
      total_len_q <= '0;
      l4_len_q    <= '0;
      csum_q      <= '0;
      beats_q     <= '0;
      beat_q      <= '0;
      last_keep_q <= '0;
      pkt_count_q <= '0;
    end else begin
      if (accept) begin
        tuple_q    <= tuple_t'(fivetuple_data_in[PKT_TUPLE_WIDTH-1:0]);
        len_q      <= LEN_W'(clamp_len(16'(pkt_len_in), 16'(MIN_PKT_LEN), 16'(MAX_PKT_LEN)));
        frame_id_q <= ip_id_q;
        ip_id_q    <= ip_id_q + 16'd1;
        beat_q     <= '0;
      end
      // Derived lengths and checksum settle here, one cycle before the first beat.
      if (state_q == S_CALC) begin
        beats_q     <= len_q[LEN_W-1:5] + BEAT_W'(|len_q[4:0]);
        total_len_q <= total_len_w;
        l4_len_q    <= (tuple_q.proto == PROTO_UDP) ? udp_len_w : 16'h0000;
        csum_q      <= csum_w;
        last_keep_q <= (len_q[4:0] == 5'd0) ? '1 : (KEEP_W'(1) << len_q[4:0]) - KEEP_W'(1);
      end
      if (beat_hs) beat_q <= beat_q + BEAT_W'(1);
      if (beat_hs && last_beat) pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign hdr_flat = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, IP_VER_IHL, IP_TOS, total_len_q,
                     frame_id_q, IP_FLAGS_DF, IP_TTL, tuple_q.proto, csum_q,
                     tuple_q.src_ip, tuple_q.dst_ip, tuple_q.src_port, tuple_q.dst_port,
                     l4_len_q, 16'h0000};

  // Beat content is a pure function of registered state, so it holds while stalled.
  always_comb begin
    logic [BEAT_W+4:0] off;
    off           = '0;
    m_axis.tvalid = frame_valid;
    m_axis.tlast  = frame_valid && last_beat;
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tuser  = '0;
    if (frame_valid) begin
      m_axis.tkeep = last_beat ? last_keep_q : '1;
      m_axis.tuser = C_M_AXIS_TUSER_WIDTH'({8'h00, SRC_PORT_TUSER, 5'b0, len_q});
      for (int i = 0; i < BEAT_BYTES; i++) begin
        off = {beat_q, 5'(i)};
        if (m_axis.tkeep[i]) begin
          if (off < (BEAT_W+5)'(HDR_BYTES))
            m_axis.tdata[8*i +: 8] = hdr_flat[8*(HDR_BYTES-1-int'(off[5:0])) +: 8];
          else
            m_axis.tdata[8*i +: 8] = off[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dflow_pkt_builder.sv
// Self-checking bench for dflow_pkt_builder: byte-level frame model, random and directed records.
module tb_dflow_pkt_builder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] fivetuple_data_in = '0;
  logic [15:0]  pkt_len_in = '0;
  logic         tuple_in_vld = 1'b0;
  logic         tuple_in_ready;
  logic [31:0]  pkt_count;

  dflow_pkt_builder_if m_axis ();

  dflow_pkt_builder dut (
    .clk               (clk),
    .rst               (rst),
    .fivetuple_data_in (fivetuple_data_in),
    .pkt_len_in        (pkt_len_in),
    .tuple_in_vld      (tuple_in_vld),
    .tuple_in_ready    (tuple_in_ready),
    .m_axis            (m_axis),
    .pkt_count         (pkt_count)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [7:0]   fb [0:2047];
  logic [15:0]  exp_id = '0;
  logic [31:0]  exp_pkts = '0;
  logic [255:0] beat0_d;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected frame bytes straight from the wire layout.
  task automatic build_frame(input logic [31:0] sip, input logic [31:0] dip,
                             input logic [15:0] sp, input logic [15:0] dp,
                             input logic [7:0] pr, input int len, input logic [15:0] id);
    logic [15:0] tl, l4, c;
    int sum;
    tl = 16'(len - 14);
    l4 = (pr == 8'h11) ? 16'(len - 34) : 16'h0000;
    for (int o = 0; o < len; o++) fb[o] = 8'(o);
    for (int o = 0; o < 6; o++) begin
      fb[o]     = 8'hFF;
      fb[6 + o] = (o == 5) ? 8'h01 : 8'h00;
    end
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[15] = 8'h00;
    fb[16] = tl[15:8]; fb[17] = tl[7:0]; fb[18] = id[15:8]; fb[19] = id[7:0];
    fb[20] = 8'h40; fb[21] = 8'h00; fb[22] = 8'h40; fb[23] = pr;
    fb[24] = 8'h00; fb[25] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      fb[26 + k] = sip[31 - 8*k -: 8];
      fb[30 + k] = dip[31 - 8*k -: 8];
    end
    fb[34] = sp[15:8]; fb[35] = sp[7:0]; fb[36] = dp[15:8]; fb[37] = dp[7:0];
    fb[38] = l4[15:8]; fb[39] = l4[7:0]; fb[40] = 8'h00; fb[41] = 8'h00;
`ifdef DFLOW_PKT_IP_CSUM_EN
    sum = 0;
    for (int k = 14; k < 34; k += 2) sum += int'({fb[k], fb[k + 1]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >>> 16);
    c = ~16'(sum);
    fb[24] = c[15:8]; fb[25] = c[7:0];
`else
    c = 16'h0000;
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_frame(input logic [31:0] sip, input logic [31:0] dip,
                           input logic [15:0] sp, input logic [15:0] dp,
                           input logic [7:0] pr, input logic [15:0] len,
                           input int stall, input int abort_at);
    int L, nb, got, cyc;
    bit aborted;
    logic [255:0] exp_d, obs_d;
    logic [31:0]  exp_k;
    L  = (len < 16'd60) ? 60 : (len > 16'd1514) ? 1514 : int'(len);
    nb = (L + 31) / 32;
    build_frame(sip, dip, sp, dp, pr, L, exp_id);
    exp_id++;

    check("in_ready_idle", 256'(tuple_in_ready), 256'(1));
    fivetuple_data_in = {24'($urandom), sip, dip, sp, dp, pr};
    pkt_len_in   = len;
    tuple_in_vld = 1'b1;
    @(negedge clk);
    tuple_in_vld      = 1'b0;
    fivetuple_data_in = {$urandom, $urandom, $urandom, $urandom};
    pkt_len_in        = 16'($urandom);
    check("bubble_tvalid", 256'(m_axis.tvalid), 256'(0));
    check("busy_in_ready", 256'(tuple_in_ready), 256'(0));
    @(negedge clk);
    check("first_tvalid", 256'(m_axis.tvalid), 256'(1));

    got = 0; cyc = 0; aborted = 1'b0;
    while (got < nb && cyc < 400 && !aborted) begin
      case (stall)
        1:       m_axis.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       m_axis.tready = ($urandom_range(0, 3) != 0);
        default: m_axis.tready = 1'b1;
      endcase
      exp_d = '0; exp_k = '0;
      for (int i = 0; i < 32; i++) begin
        if (got*32 + i < L) begin
          exp_d[8*i +: 8] = fb[got*32 + i];
          exp_k[i] = 1'b1;
        end
      end
      obs_d = m_axis.tdata;
      for (int i = 0; i < 32; i++) if (!exp_k[i]) obs_d[8*i +: 8] = 8'h00;
      check("beat_tvalid", 256'(m_axis.tvalid), 256'(1));
      check("beat_tdata", obs_d, exp_d);
      check("beat_tkeep", 256'(m_axis.tkeep), 256'(exp_k));
      check("beat_tlast", 256'(m_axis.tlast), 256'(got == nb - 1));
      check("beat_tuser", 256'(m_axis.tuser), 256'({8'h00, 8'h01, 16'(L)}));
      check("beat_in_ready", 256'(tuple_in_ready), 256'(0));
      if (got == 0) beat0_d = m_axis.tdata;
      if (got == abort_at) begin
        rst = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clk);
      if (m_axis.tready && !aborted) got++;
      cyc++;
    end

    if (aborted) begin
      check("abort_tvalid", 256'(m_axis.tvalid), 256'(0));
      check("abort_tlast", 256'(m_axis.tlast), 256'(0));
      check("abort_pkt_count", 256'(pkt_count), 256'(0));
      check("abort_in_ready_rst", 256'(tuple_in_ready), 256'(0));
      rst = 1'b0;
      exp_id = '0;
      exp_pkts = '0;
      @(negedge clk);
      check("abort_in_ready_after", 256'(tuple_in_ready), 256'(1));
    end else begin
      check("beat_count", 256'(got), 256'(nb));
      exp_pkts++;
      check("pkt_count", 256'(pkt_count), 256'(exp_pkts));
      check("idle_tvalid", 256'(m_axis.tvalid), 256'(0));
      check("idle_in_ready", 256'(tuple_in_ready), 256'(1));
    end
    m_axis.tready = 1'b1;
  endtask

  initial begin
    m_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(tuple_in_ready), 256'(0));
    check("rst_tvalid", 256'(m_axis.tvalid), 256'(0));
    check("rst_tlast", 256'(m_axis.tlast), 256'(0));
    check("rst_tdata", m_axis.tdata, 256'(0));
    check("rst_tkeep", 256'(m_axis.tkeep), 256'(0));
    check("rst_tuser", 256'(m_axis.tuser), 256'(0));
    check("rst_pkt_count", 256'(pkt_count), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // First record after reset: known header values.
    run_frame(32'hC0A80001, 32'hC0A800C7, 16'h1234, 16'h5678, 8'h11, 16'd129, 0, -1);
    check("first_total_len", 256'({beat0_d[135:128], beat0_d[143:136]}), 256'(16'h0073));
    check("first_ip_id", 256'({beat0_d[151:144], beat0_d[159:152]}), 256'(16'h0000));
`ifdef DFLOW_PKT_IP_CSUM_EN
    check("first_csum", 256'({beat0_d[199:192], beat0_d[207:200]}), 256'(16'hB861));
`else
    check("first_csum", 256'({beat0_d[199:192], beat0_d[207:200]}), 256'(16'h0000));
`endif

    // Minimum, odd and clamped lengths.
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h11, 16'd60, 0, -1);
    check("len60_total_len", 256'({beat0_d[135:128], beat0_d[143:136]}), 256'(16'h002E));
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h06, 16'd100, 0, -1);
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h11, 16'd20, 0, -1);
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h06, 16'd2000, 0, -1);
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h11, 16'd64, 0, -1);
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h11, 16'd65, 0, -1);

    // Back-pressure: fixed 1-0-0-1 pattern, then random records with random stalls.
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h11, 16'd200, 1, -1);
    for (int n = 0; n < 8; n++) begin
      run_frame($urandom, $urandom, 16'($urandom), 16'($urandom),
                ($urandom_range(0, 1) != 0) ? 8'h11 : 8'($urandom),
                16'($urandom_range(0, 1700)), 2, -1);
    end

    // Reset while the third beat of a maximum-size frame is on the bus.
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h11, 16'd1514, 0, 2);
    run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 8'h11, 16'd90, 2, -1);
    check("post_rst_ip_id", 256'({beat0_d[151:144], beat0_d[159:152]}), 256'(16'h0000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
